// File: rtl/mips_regfile_sb.sv
// MIPS register file with write-through bypass and a per-register pending-write
// scoreboard: reservations at issue, commits at writeback, stall on busy operands.
module mips_regfile_sb #(
  parameter int WIDTH  = 32,
  parameter int PEND_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       A1,
  input  logic [4:0]       A2,
  output logic [WIDTH-1:0] RD1,
  output logic [WIDTH-1:0] RD2,
  input  logic             iss_valid,
  input  logic [4:0]       iss_A3,
  output logic             iss_ready,
  input  logic             WE3,
  input  logic [4:0]       A3,
  input  logic [WIDTH-1:0] WD3,
  output logic             stall,
  output logic             err
);

  logic [WIDTH-1:0]  regs [32];
  logic [PEND_W-1:0] cnt  [32];
  logic [31:0]       inc_vec;
  logic [31:0]       dec_vec;
  logic              accept;
  logic              busy1;
  logic              busy2;

  // A commit in the same cycle frees one slot, so a full counter can still accept.
  always_comb begin
    iss_ready = 1'b1;
    if (!reset && iss_A3 != 5'd0 && (&cnt[iss_A3]) && !(WE3 && A3 == iss_A3))
      iss_ready = 1'b0;
  end

  assign accept = iss_valid && iss_ready && (iss_A3 != 5'd0) && !reset;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (accept)
      inc_vec = 32'd1 << iss_A3;
    for (int i = 1; i < 32; i++)
      dec_vec[i] = WE3 && (A3 == 5'(i)) && (cnt[i] != '0);
  end

  always_comb begin
    RD1 = '0;
    if (!reset && A1 != 5'd0)
      RD1 = (WE3 && A3 == A1) ? WD3 : regs[A1];
  end

  always_comb begin
    RD2 = '0;
    if (!reset && A2 != 5'd0)
      RD2 = (WE3 && A3 == A2) ? WD3 : regs[A2];
  end

  // The final outstanding commit clears busy within its own cycle.
  always_comb begin
    busy1 = (A1 != 5'd0) && (cnt[A1] != '0) &&
            !(WE3 && A3 == A1 && cnt[A1] == PEND_W'(1));
    busy2 = (A2 != 5'd0) && (cnt[A2] != '0) &&
            !(WE3 && A3 == A2 && cnt[A2] == PEND_W'(1));
    stall = !reset && (busy1 || busy2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      err <= 1'b0;
    end else begin
      if (WE3 && A3 != 5'd0) begin
        regs[A3] <= WD3;
        if (cnt[A3] == '0)
          err <= 1'b1;
      end
      for (int i = 1; i < 32; i++) begin
        if (inc_vec[i] && !dec_vec[i])
          cnt[i] <= cnt[i] + PEND_W'(1);
        else if (dec_vec[i] && !inc_vec[i])
          cnt[i] <= cnt[i] - PEND_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mips_regfile_sb.sv
// Directed bench for mips_regfile_sb: reads, bypass, scoreboard stall/ready,
// counter saturation, register 0 handling, sticky err and asynchronous reset.
module tb_mips_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2, iss_A3, A3;
  logic [31:0] RD1, RD2, WD3;
  logic        iss_valid, iss_ready, WE3, stall, err;

  int passed = 0;
  int total  = 0;

  mips_regfile_sb #(.WIDTH(32), .PEND_W(2)) dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .iss_valid(iss_valid), .iss_A3(iss_A3), .iss_ready(iss_ready),
    .WE3(WE3), .A3(A3), .WD3(WD3), .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; A1 = 5'd5; A2 = 5'd0; iss_valid = 1'b0; iss_A3 = 5'd0;
    WE3 = 1'b0; A3 = 5'd0; WD3 = '0;
    #1;
    chk("rst_during_rd1", RD1, 32'd0);
    chk("rst_during_ready", {31'd0, iss_ready}, 32'd1);
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_rd1", RD1, 32'd0);
    chk("rst_rd2", RD2, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_ready", {31'd0, iss_ready}, 32'd1);
    chk("rst_err", {31'd0, err}, 32'd0);

    // Reserve r8, then commit with bypass
    step();
    iss_valid = 1'b1; iss_A3 = 5'd8;
    step();
    iss_valid = 1'b0; A1 = 5'd8;
    #1;
    chk("r8_stall_pending", {31'd0, stall}, 32'd1);
    WE3 = 1'b1; A3 = 5'd8; WD3 = 32'hDEADBEEF;
    #1;
    chk("r8_bypass_rd1", RD1, 32'hDEADBEEF);
    chk("r8_stall_clear", {31'd0, stall}, 32'd0);
    step();
    WE3 = 1'b0;
    #1;
    chk("r8_storage_rd1", RD1, 32'hDEADBEEF);
    chk("r8_no_err", {31'd0, err}, 32'd0);

    // Saturate r3 at three outstanding writes
    iss_valid = 1'b1; iss_A3 = 5'd3;
    step(); step(); step();
    iss_valid = 1'b0; A1 = 5'd3;
    #1;
    chk("r3_full_ready", {31'd0, iss_ready}, 32'd0);
    chk("r3_full_stall", {31'd0, stall}, 32'd1);
    WE3 = 1'b1; A3 = 5'd3; WD3 = 32'h33;
    #1;
    chk("r3_commit_ready", {31'd0, iss_ready}, 32'd1);
    iss_valid = 1'b1;
    step();
    iss_valid = 1'b0; WE3 = 1'b0;
    #1;
    chk("r3_issue_commit_keeps3", {31'd0, iss_ready}, 32'd0);
    WE3 = 1'b1; WD3 = 32'h31;
    #1;
    chk("r3_drain1_stall", {31'd0, stall}, 32'd1);
    step();
    WD3 = 32'h32;
    #1;
    chk("r3_drain2_stall", {31'd0, stall}, 32'd1);
    step();
    WD3 = 32'h3F;
    #1;
    chk("r3_last_commit_stall", {31'd0, stall}, 32'd0);
    step();
    WE3 = 1'b0;
    #1;
    chk("r3_final_data", RD1, 32'h3F);
    chk("r3_ready_after", {31'd0, iss_ready}, 32'd1);
    chk("r3_no_err", {31'd0, err}, 32'd0);

    // Register 0 ignores writes and reservations
    WE3 = 1'b1; A3 = 5'd0; WD3 = 32'h1234; iss_valid = 1'b1; iss_A3 = 5'd0; A1 = 5'd0;
    #1;
    chk("r0_bypass_rd1", RD1, 32'd0);
    chk("r0_ready", {31'd0, iss_ready}, 32'd1);
    step();
    WE3 = 1'b0; iss_valid = 1'b0;
    #1;
    chk("r0_rd1", RD1, 32'd0);
    chk("r0_stall", {31'd0, stall}, 32'd0);
    chk("r0_err", {31'd0, err}, 32'd0);

    // Unreserved writeback to r9 still writes and sets err
    WE3 = 1'b1; A3 = 5'd9; WD3 = 32'h99;
    step();
    WE3 = 1'b0; A1 = 5'd9;
    #1;
    chk("r9_written", RD1, 32'h99);
    chk("r9_err_set", {31'd0, err}, 32'd1);
    chk("r9_cnt_zero_stall", {31'd0, stall}, 32'd0);
    step();
    chk("r9_err_sticky", {31'd0, err}, 32'd1);

    // Two operands pending
    iss_valid = 1'b1; iss_A3 = 5'd4;
    step();
    iss_A3 = 5'd7;
    step();
    iss_valid = 1'b0; A1 = 5'd4; A2 = 5'd7;
    #1;
    chk("pair_stall", {31'd0, stall}, 32'd1);
    WE3 = 1'b1; A3 = 5'd4; WD3 = 32'h44;
    #1;
    chk("pair_commit4_stall", {31'd0, stall}, 32'd1);
    step();
    A3 = 5'd7; WD3 = 32'h77;
    #1;
    chk("pair_commit7_stall", {31'd0, stall}, 32'd0);
    chk("pair_rd2_bypass", RD2, 32'h77);
    step();
    WE3 = 1'b0;
    #1;
    chk("pair_idle_stall", {31'd0, stall}, 32'd0);
    chk("pair_rd1", RD1, 32'h44);
    chk("pair_rd2", RD2, 32'h77);

    // Build cnt[4]=2, R[4]=0x55, then reset mid-cycle
    A2 = 5'd0; iss_valid = 1'b1; iss_A3 = 5'd4;
    step(); step();
    WE3 = 1'b1; A3 = 5'd4; WD3 = 32'h55;
    step();
    iss_valid = 1'b0; WE3 = 1'b0;
    #1;
    chk("pre_rst_rd1", RD1, 32'h55);
    chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_rd1", RD1, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_rst_ready", {31'd0, iss_ready}, 32'd1);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("post_rst_rd1", RD1, 32'd0);
    chk("post_rst_stall", {31'd0, stall}, 32'd0);
    chk("post_rst_ready", {31'd0, iss_ready}, 32'd1);
    step();
    chk("post_rst_err", {31'd0, err}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
